// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package prog_loader_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LEN_LO = 3'd1,
      LEN_HI = 3'd2,
      DATA   = 3'd3,
      CSUM   = 3'd4,
      DONE   = 3'd5,
      ERROR  = 3'd6
   } loader_state_t;

   localparam logic [7:0] LOADER_HDR = 8'hA5;

   function automatic logic is_frame_state(loader_state_t s);
      return (s == LEN_LO) || (s == LEN_HI) || (s == DATA) || (s == CSUM);
   endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte stream in, instruction-memory write port and CPU boot status out.
interface prog_loader_if #(parameter int ADDR_W = 10);
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              cpu_rst;
   logic              done;
   logic              error;

   modport master (
      output rx_data, rx_valid,
      input  imem_we, imem_addr, imem_wdata, cpu_rst, done, error
   );

   modport slave (
      input  rx_data, rx_valid,
      output imem_we, imem_addr, imem_wdata, cpu_rst, done, error
   );
endinterface

// File: rtl/prog_loader.sv
// Frame parser that packs bytes into imem words and releases the CPU reset
// only after a frame with a matching XOR checksum.
//
// state  | meaning
// IDLE   | no frame seen since reset, CPU held in reset
// LEN_LO | expecting low byte of word count
// LEN_HI | expecting high byte of word count
// DATA   | collecting payload bytes, LSB first
// CSUM   | expecting XOR of all payload bytes
// DONE   | program loaded, CPU running
// ERROR  | bad length, checksum or timeout; CPU held in reset
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int         ADDR_W  = 10,
   parameter int         TIMEOUT = 100000,
   parameter logic [7:0] HDR     = LOADER_HDR
) (
   input  logic       clk,
   input  logic       rst,
   prog_loader_if.slave bus
);

   localparam int TW = $clog2(TIMEOUT + 1);

   loader_state_t     state, state_nxt;
   logic [15:0]       len, len_nxt;
   logic [1:0]        byte_cnt, byte_cnt_nxt;
   logic [ADDR_W:0]   word_cnt, word_cnt_nxt;
   logic [23:0]       shift, shift_nxt;
   logic [7:0]        xor_acc, xor_acc_nxt;
   logic [TW-1:0]     idle_cnt, idle_cnt_nxt;
   logic              we_q, we_nxt;
   logic [ADDR_W-1:0] addr_q, addr_nxt;
   logic [31:0]       wdata_q, wdata_nxt;
   logic              cpu_rst_q, cpu_rst_nxt;
   logic              done_q, done_nxt;
   logic              error_q, error_nxt;
   logic [15:0]       n_words;
   logic [ADDR_W:0]   word_inc;

   assign n_words  = {bus.rx_data, len[7:0]};
   assign word_inc = word_cnt + 1'b1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         len       <= '0;
         byte_cnt  <= '0;
         word_cnt  <= '0;
         shift     <= '0;
         xor_acc   <= '0;
         idle_cnt  <= '0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         cpu_rst_q <= 1'b1;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         state     <= state_nxt;
         len       <= len_nxt;
         byte_cnt  <= byte_cnt_nxt;
         word_cnt  <= word_cnt_nxt;
         shift     <= shift_nxt;
         xor_acc   <= xor_acc_nxt;
         idle_cnt  <= idle_cnt_nxt;
         we_q      <= we_nxt;
         addr_q    <= addr_nxt;
         wdata_q   <= wdata_nxt;
         cpu_rst_q <= cpu_rst_nxt;
         done_q    <= done_nxt;
         error_q   <= error_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      len_nxt      = len;
      byte_cnt_nxt = byte_cnt;
      word_cnt_nxt = word_cnt;
      shift_nxt    = shift;
      xor_acc_nxt  = xor_acc;
      idle_cnt_nxt = '0;
      we_nxt       = 1'b0;
      addr_nxt     = addr_q;
      wdata_nxt    = wdata_q;
      cpu_rst_nxt  = cpu_rst_q;
      done_nxt     = done_q;
      error_nxt    = error_q;

      case (state)
         IDLE, DONE, ERROR: begin
            if (bus.rx_valid && bus.rx_data == HDR) begin
               state_nxt    = LEN_LO;
               cpu_rst_nxt  = 1'b1;
               done_nxt     = 1'b0;
               error_nxt    = 1'b0;
               byte_cnt_nxt = '0;
               word_cnt_nxt = '0;
               xor_acc_nxt  = '0;
            end
         end
         LEN_LO: begin
            if (bus.rx_valid) begin
               len_nxt   = {8'h00, bus.rx_data};
               state_nxt = LEN_HI;
            end
         end
         LEN_HI: begin
            if (bus.rx_valid) begin
               len_nxt = n_words;
               if (int'(n_words) > (1 << ADDR_W)) begin
                  state_nxt = ERROR;
                  error_nxt = 1'b1;
               end else if (n_words == 16'd0) begin
                  state_nxt = CSUM;
               end else begin
                  state_nxt = DATA;
               end
            end
         end
         DATA: begin
            if (bus.rx_valid) begin
               xor_acc_nxt  = xor_acc ^ bus.rx_data;
               byte_cnt_nxt = byte_cnt + 1'b1;
               if (byte_cnt == 2'd3) begin
                  we_nxt       = 1'b1;
                  addr_nxt     = word_cnt[ADDR_W-1:0];
                  wdata_nxt    = {bus.rx_data, shift};
                  word_cnt_nxt = word_inc;
                  if (16'(word_inc) == len)
                     state_nxt = CSUM;
               end else begin
                  shift_nxt[{byte_cnt, 3'b000} +: 8] = bus.rx_data;
               end
            end
         end
         CSUM: begin
            if (bus.rx_valid) begin
               if (bus.rx_data == xor_acc) begin
                  state_nxt   = DONE;
                  done_nxt    = 1'b1;
                  cpu_rst_nxt = 1'b0;
               end else begin
                  state_nxt = ERROR;
                  error_nxt = 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase

      // Inter-byte watchdog; a stall inside a frame aborts it.
      if (is_frame_state(state) && !bus.rx_valid) begin
         if (int'(idle_cnt) + 1 >= TIMEOUT) begin
            state_nxt = ERROR;
            error_nxt = 1'b1;
         end else begin
            idle_cnt_nxt = idle_cnt + 1'b1;
         end
      end
   end

   assign bus.imem_we    = we_q;
   assign bus.imem_addr  = addr_q;
   assign bus.imem_wdata = wdata_q;
   assign bus.cpu_rst    = cpu_rst_q;
   assign bus.done       = done_q;
   assign bus.error      = error_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed frames against prog_loader with a write scoreboard checked by a monitor.
module tb_prog_loader;
   import prog_loader_pkg::*;

   localparam int ADDR_W  = 10;
   localparam int TIMEOUT = 50;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
   } wr_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   failures = 0;
   wr_t  exp_q[$];

   prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

   prog_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst && bus.imem_we) begin
         wr_t e;
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write: got addr %h data %h expected none", bus.imem_addr, bus.imem_wdata);
         end else begin
            e = exp_q.pop_front();
            chk("write_addr", 32'(bus.imem_addr), 32'(e.addr));
            chk("write_data", bus.imem_wdata, e.data);
         end
      end
   end

   task automatic send(input logic [7:0] bytes[$]);
      foreach (bytes[i]) begin
         @(negedge clk);
         bus.rx_data  = bytes[i];
         bus.rx_valid = 1'b1;
      end
      @(negedge clk);
      bus.rx_valid = 1'b0;
   endtask

   task automatic expect_wr(input logic [ADDR_W-1:0] a, input logic [31:0] d);
      wr_t e;
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      logic [7:0] good[$] = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00,
                              8'h93, 8'h00, 8'h10, 8'h00, 8'hC0};
      logic [7:0] bad[$]  = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00,
                              8'h93, 8'h00, 8'h10, 8'h00, 8'hC1};
      logic stable;
      int   k;

      bus.rx_data  = 8'h00;
      bus.rx_valid = 1'b0;

      // reset state
      idle(2);
      chk("rst_cpu_rst", 32'(bus.cpu_rst), 32'd1);
      chk("rst_we", 32'(bus.imem_we), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_error", 32'(bus.error), 32'd0);
      rst = 1'b1;
      stable = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (bus.cpu_rst !== 1'b1 || bus.done !== 1'b0 || bus.error !== 1'b0 || bus.imem_we !== 1'b0)
            stable = 1'b0;
      end
      chk("idle_stable", 32'(stable), 32'd1);

      // valid two-word frame
      expect_wr(10'd0, 32'h00500013);
      expect_wr(10'd1, 32'h00100093);
      send(good);
      chk("good_done", 32'(bus.done), 32'd1);
      chk("good_cpu_rst", 32'(bus.cpu_rst), 32'd0);
      chk("good_error", 32'(bus.error), 32'd0);
      chk("good_q_empty", 32'(exp_q.size()), 32'd0);

      // reload from DONE re-asserts CPU reset, then bad checksum
      @(negedge clk);
      bus.rx_data = 8'hA5;
      bus.rx_valid = 1'b1;
      @(negedge clk);
      bus.rx_valid = 1'b0;
      chk("reload_cpu_rst", 32'(bus.cpu_rst), 32'd1);
      chk("reload_done", 32'(bus.done), 32'd0);
      expect_wr(10'd0, 32'h00500013);
      expect_wr(10'd1, 32'h00100093);
      bad.pop_front();
      send(bad);
      chk("bad_error", 32'(bus.error), 32'd1);
      chk("bad_cpu_rst", 32'(bus.cpu_rst), 32'd1);
      chk("bad_done", 32'(bus.done), 32'd0);
      chk("bad_q_empty", 32'(exp_q.size()), 32'd0);

      expect_wr(10'd0, 32'h00500013);
      expect_wr(10'd1, 32'h00100093);
      send(good);
      chk("resend_done", 32'(bus.done), 32'd1);
      chk("resend_cpu_rst", 32'(bus.cpu_rst), 32'd0);

      // empty frame and oversized length
      send('{8'hA5, 8'h00, 8'h00, 8'h00});
      chk("empty_done", 32'(bus.done), 32'd1);
      chk("empty_cpu_rst", 32'(bus.cpu_rst), 32'd0);
      send('{8'hA5, 8'h01, 8'h04});
      chk("oversize_error", 32'(bus.error), 32'd1);
      chk("oversize_cpu_rst", 32'(bus.cpu_rst), 32'd1);

      // stray bytes ignored, then timeout mid-word
      send('{8'h13, 8'hFF, 8'h00});
      chk("stray_error", 32'(bus.error), 32'd1);
      send('{8'hA5, 8'h01, 8'h00, 8'h13});
      chk("to_cleared", 32'(bus.error), 32'd0);
      k = 0;
      while (bus.error !== 1'b1 && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk("timeout_cycles", 32'(k), 32'(TIMEOUT));
      chk("timeout_cpu_rst", 32'(bus.cpu_rst), 32'd1);

      // async reset mid-DATA discards partial word
      send('{8'hA5, 8'h01, 8'h00, 8'h13, 8'h50});
      #2;
      rst = 1'b0;
      #1;
      chk("arst_cpu_rst", 32'(bus.cpu_rst), 32'd1);
      chk("arst_we", 32'(bus.imem_we), 32'd0);
      chk("arst_addr", 32'(bus.imem_addr), 32'd0);
      chk("arst_wdata", bus.imem_wdata, 32'd0);
      chk("arst_done", 32'(bus.done), 32'd0);
      chk("arst_error", 32'(bus.error), 32'd0);
      idle(2);
      rst = 1'b1;
      expect_wr(10'd0, 32'h44332211);
      send('{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44});
      chk("after_rst_done", 32'(bus.done), 32'd1);
      chk("after_rst_cpu_rst", 32'(bus.cpu_rst), 32'd0);

      idle(3);
      chk("final_q_empty", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
